// File: rtl/seg7_capture.sv
// seg7_capture: glitch-filtered readback of an active-low 7-segment bus.
// Settled legal digits are delivered through a one-entry valid/ready buffer.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] hex,
  input  logic       out_ready,
  input  logic       clear_err,
  output logic [3:0] value,
  output logic       out_valid,
  output logic       blank,
  output logic       illegal,
  output logic       overrun,
  output logic [7:0] change_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [6:0]    sample_q;
  logic [6:0]    committed;
  logic [CW-1:0] stab_cnt;

  logic       differ;
  logic       settled;
  logic       commit;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic       pop;
  logic       load;
  logic       pop_only;
  logic       drop;
  logic       bad;

  assign differ  = hex != sample_q;
  assign settled = !differ && (stab_cnt == CMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= BLANK;
      stab_cnt <= '0;
    end else if (differ) begin
      sample_q <= hex;
      stab_cnt <= CW'(1);
    end else if (stab_cnt != CMAX) begin
      stab_cnt <= stab_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a glitch back to the committed pattern abandons the settle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (differ && (hex != committed)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if ((differ && (hex == committed)) || settled) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    commit = (state_q == SETTLE) && settled;
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (sample_q)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'ha;
      7'b0000011: dec_val = 4'hb;
      7'b1000110: dec_val = 4'hc;
      7'b0100001: dec_val = 4'hd;
      7'b0000110: dec_val = 4'he;
      7'b0001110: dec_val = 4'hf;
      default:    dec_ok  = 1'b0;
    endcase
  end

  assign pop      = out_valid && out_ready;
  assign load     = commit && dec_ok && (!out_valid || out_ready);
  assign pop_only = pop && !load;
  assign drop     = commit && dec_ok && out_valid && !out_ready;
  assign bad      = commit && !dec_ok && (sample_q != BLANK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      committed <= BLANK;
      blank     <= 1'b1;
    end else if (commit) begin
      committed <= sample_q;
      blank     <= sample_q == BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value        <= 4'h0;
      out_valid    <= 1'b0;
      change_count <= 8'd0;
    end else begin
      unique case (1'b1)
        load: begin
          value        <= dec_val;
          out_valid    <= 1'b1;
          change_count <= change_count + 8'd1;
        end
        pop_only: out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // a set on the same edge as clear_err wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
      overrun <= 1'b0;
    end else begin
      illegal <= bad || (illegal && !clear_err);
      overrun <= drop || (overrun && !clear_err);
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed vector table, reset/wrap sequences and
// randomized bursts checked against a sample-window reference model.
module tb_seg7_capture;

  localparam int S = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] hex;
  logic       out_ready;
  logic       clear_err;
  logic [3:0] value;
  logic       out_valid;
  logic       blank;
  logic       illegal;
  logic       overrun;
  logic [7:0] change_count;

  int vecs;
  int miscmp;

  logic [6:0] seg [16];
  logic [6:0] hist [$];
  logic [6:0] m_comm;
  logic [3:0] m_val;
  logic       m_vld;
  logic       m_blk;
  logic       m_ill;
  logic       m_ovr;
  logic [7:0] m_cnt;

  typedef struct {
    logic [6:0] h;
    logic       rdy;
    logic       clr;
    int         n;
    logic [3:0] val;
    logic       vld;
    logic       blk;
    logic       ill;
    logic       ovr;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [$];

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .hex          (hex),
    .out_ready    (out_ready),
    .clear_err    (clear_err),
    .value        (value),
    .out_valid    (out_valid),
    .blank        (blank),
    .illegal      (illegal),
    .overrun      (overrun),
    .change_count (change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic int decode(logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (seg[i] == p) return i;
    end
    if (p == 7'h7f) return 16;
    return 17;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_comm = 7'h7f;
    m_val  = 4'h0;
    m_vld  = 1'b0;
    m_blk  = 1'b1;
    m_ill  = 1'b0;
    m_ovr  = 1'b0;
    m_cnt  = 8'd0;
  endfunction

  // A pattern commits once the last S+1 samples since reset all equal it
  // and it differs from what is currently committed.
  function automatic void model_edge(logic [6:0] h, logic rdy, logic clr);
    bit com;
    bit si;
    bit so;
    int d;
    si = 1'b0;
    so = 1'b0;
    hist.push_back(h);
    if (hist.size() > S + 1) void'(hist.pop_front());
    com = (hist.size() == S + 1) && (h != m_comm);
    foreach (hist[i]) begin
      if (hist[i] != h) com = 1'b0;
    end
    if (m_vld && rdy) m_vld = 1'b0;
    if (com) begin
      m_comm = h;
      d = decode(h);
      m_blk = (d == 16);
      if (d < 16) begin
        if (m_vld) begin
          so = 1'b1;
        end else begin
          m_val = 4'(d);
          m_vld = 1'b1;
          m_cnt = m_cnt + 8'd1;
        end
      end else if (d == 17) begin
        si = 1'b1;
      end
    end
    m_ill = si || (m_ill && !clr);
    m_ovr = so || (m_ovr && !clr);
  endfunction

  task automatic check_out(string tag, logic [3:0] v, logic vl, logic bk,
                           logic il, logic ov, logic [7:0] cn);
    chk({tag, ".value"}, value, v);
    chk({tag, ".out_valid"}, out_valid, vl);
    chk({tag, ".blank"}, blank, bk);
    chk({tag, ".illegal"}, illegal, il);
    chk({tag, ".overrun"}, overrun, ov);
    chk({tag, ".change_count"}, change_count, cn);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(hex, out_ready, clear_err);
    #1;
    check_out("model", m_val, m_vld, m_blk, m_ill, m_ovr, m_cnt);
  endtask

  task automatic drive(logic [6:0] h, logic r, logic c);
    hex       = h;
    out_ready = r;
    clear_err = c;
  endtask

  task automatic add(logic [6:0] h, logic r, logic c, int n,
                     logic [3:0] v, logic vl, logic bk, logic il,
                     logic ov, logic [7:0] cn);
    vec_t e;
    e.h = h;   e.rdy = r;  e.clr = c;  e.n = n;
    e.val = v; e.vld = vl; e.blk = bk; e.ill = il;
    e.ovr = ov; e.cnt = cn;
    tbl.push_back(e);
  endtask

  initial begin
    seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
    vecs   = 0;
    miscmp = 0;

    drive(7'h7f, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    //  hex    rdy clr  n  val vld blk ill ovr cnt
    add(7'h7f, 0, 0, 20, 4'h0, 0, 1, 0, 0, 8'd0);
    add(7'h24, 0, 0,  4, 4'h0, 0, 1, 0, 0, 8'd0);
    add(7'h24, 0, 0,  1, 4'h2, 1, 0, 0, 0, 8'd1);
    add(7'h24, 1, 0,  1, 4'h2, 0, 0, 0, 0, 8'd1);
    add(7'h30, 0, 0,  2, 4'h2, 0, 0, 0, 0, 8'd1);
    add(7'h19, 0, 0,  5, 4'h4, 1, 0, 0, 0, 8'd2);
    add(7'h19, 1, 0,  1, 4'h4, 0, 0, 0, 0, 8'd2);
    add(7'h55, 0, 0,  6, 4'h4, 0, 0, 1, 0, 8'd2);
    add(7'h55, 0, 1,  1, 4'h4, 0, 0, 0, 0, 8'd2);
    add(7'h12, 0, 0,  5, 4'h5, 1, 0, 0, 0, 8'd3);
    add(7'h02, 0, 0,  5, 4'h5, 1, 0, 0, 1, 8'd3);
    add(7'h02, 0, 1,  1, 4'h5, 1, 0, 0, 0, 8'd3);
    add(7'h7f, 0, 0,  5, 4'h5, 1, 1, 0, 0, 8'd3);
    add(7'h02, 0, 0,  4, 4'h5, 1, 1, 0, 0, 8'd3);
    add(7'h02, 1, 0,  1, 4'h6, 1, 0, 0, 0, 8'd4);
    add(7'h02, 0, 0,  3, 4'h6, 1, 0, 0, 0, 8'd4);
    add(7'h00, 0, 0,  3, 4'h6, 1, 0, 0, 0, 8'd4);
    add(7'h02, 0, 0,  6, 4'h6, 1, 0, 0, 0, 8'd4);
    add(7'h02, 1, 0,  1, 4'h6, 0, 0, 0, 0, 8'd4);
    add(7'h7f, 0, 0,  5, 4'h6, 0, 1, 0, 0, 8'd4);
    add(7'h02, 0, 0,  5, 4'h6, 1, 0, 0, 0, 8'd5);
    add(7'h55, 0, 1,  5, 4'h6, 1, 0, 1, 0, 8'd5);
    add(7'h08, 0, 0,  5, 4'h6, 1, 0, 1, 1, 8'd5);
    add(7'h08, 1, 1,  1, 4'h6, 0, 0, 0, 0, 8'd5);

    foreach (tbl[k]) begin
      drive(tbl[k].h, tbl[k].rdy, tbl[k].clr);
      repeat (tbl[k].n) step();
      check_out($sformatf("vec%0d", k), tbl[k].val, tbl[k].vld,
                tbl[k].blk, tbl[k].ill, tbl[k].ovr, tbl[k].cnt);
    end

    // reset in the middle of a settle
    drive(7'h03, 1'b0, 1'b0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out("rst_async", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("rst_hold", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    repeat (S) step();
    check_out("rst_pre", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    check_out("rst_commit", 4'hb, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

    // counter wrap: 255 more commits take it from 1 back to 0
    for (int i = 0; i < 255; i++) begin
      drive((i % 2 == 0) ? 7'h46 : 7'h03, 1'b1, 1'b0);
      repeat (S + 1) step();
    end
    chk("wrap.change_count", change_count, 8'd0);

    for (int b = 0; b < 700; b++) begin
      int sel;
      int hold;
      logic [6:0] p;
      sel  = $urandom_range(0, 99);
      hold = $urandom_range(1, S + 3);
      if (sel < 70) p = seg[$urandom_range(0, 15)];
      else if (sel < 85) p = 7'h7f;
      else p = 7'($urandom);
      for (int j = 0; j < hold; j++) begin
        drive(p, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side companion to the hex-to-seven-segment encoder: monitors an active-low 7-segment pattern bus, filters glitches, and decodes stable patterns back to a 4-bit hex value. Each newly settled legal digit is delivered through a one-entry valid/ready output buffer. Used in the parking-lot display path to read back what the HEX displays show (self-check) and to count display updates.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed; legal range ≥1.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- hex  input  7  active-low segment pattern, same bit encoding as the display encoder.
- out_ready  input  1  consumer accepts the buffered value on a rising edge where out_valid=1.
- clear_err  input  1  synchronous clear of the illegal and overrun flags.
- value  output  4  decoded digit held in the output buffer.
- out_valid  output  1  output buffer full.
- blank  output  1  committed pattern is all segments off (7'b1111111).
- illegal  output  1  sticky; a non-table, non-blank pattern was committed.
- overrun  output  1  sticky; a legal digit was dropped because the buffer was full.
- change_count  output  8  number of legal digits accepted into the buffer; wraps 255→0.

## Operation
- Decode table (hex → value): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F. Pattern 1111111 is blank. All other patterns are illegal.
- Internal registers:
  - sample_q (7 bits), last sampled pattern.
  - stab_cnt, width $clog2(STABLE_CYCLES+1), saturates at STABLE_CYCLES.
  - committed (7 bits).
  - FSM state, IDLE or SETTLE.
- Sampling: on each edge, if hex≠sample_q, load sample_q=hex and set stab_cnt=1. Otherwise increment stab_cnt up to saturation.
- FSM transitions:
  - IDLE → SETTLE when a newly loaded sample_q differs from committed.
  - SETTLE → IDLE without commit when sample_q returns to committed.
  - SETTLE → IDLE with commit on the edge after stab_cnt reached STABLE_CYCLES while hex still equals sample_q.
- Commit actions:
  - Load committed=sample_q.
  - Set blank = (pattern is blank).
  - Legal digit, buffer empty or popped on the same edge: load value, set out_valid=1, increment change_count.
  - Legal digit, buffer full and not popped: keep value, set overrun=1, no count increment.
  - Illegal pattern: set illegal=1; no buffer change.
  - Blank: no buffer change.
- Handshake: out_valid stays high until an edge with out_ready=1, then clears. out_ready with out_valid=0 is ignored. A pop and a legal commit on the same edge load the new value, keep out_valid=1, and do not set overrun.
- clear_err=1 clears illegal and overrun on the next edge. If a set event occurs on the same edge, set wins.
- Reset values, asserted immediately on reset going low:
  - sample_q=7'b1111111, committed=7'b1111111, stab_cnt=0, state IDLE.
  - value=0, out_valid=0, blank=1, illegal=0, overrun=0, change_count=0.

## Timing
- Number the first edge that samples a new pattern P as edge 1. With P held steady, the commit occurs at edge STABLE_CYCLES+1, and outputs update after that edge.
  - STABLE_CYCLES=4: out_valid rises after edge 5.
  - STABLE_CYCLES=1: out_valid rises after edge 2.
- Any differing sample before commit restarts the count from that edge. A pattern shorter than STABLE_CYCLES samples is never committed.
- Re-holding the committed pattern causes no commit. A repeated digit is only reported after an intervening different pattern (e.g. blank) has itself committed.
- Buffer throughput: one value per cycle maximum; no combinational path from out_ready to out_valid.
- Reset mid-SETTLE aborts the settle. After release, an unchanged non-blank hex needs the full STABLE_CYCLES+1 edges before it commits.

## Test plan
- Reset with hex=1111111 held for 20 cycles → out_valid=0, blank=1, change_count=0 throughout.
- STABLE_CYCLES=4, hex=0100100 held, out_ready=0 → out_valid=1, value=2, blank=0, change_count=1 after edge 5. Raise out_ready → out_valid=0 after next edge.
- hex=0110000 for 2 cycles, then 0011001 held → only value=4 delivered, change_count increments by exactly 1, value 3 never appears.
- hex=1010101 held 6 cycles → illegal=1, out_valid unchanged, blank=0. Pulse clear_err → illegal=0.
- Value 5 pending with out_ready=0, then commit 6 → overrun=1, value stays 5. Repeat with out_ready=1 on the commit edge → value=6, out_valid=1, overrun stays 0.
- Drive reset low in mid-SETTLE at cycle 3 of 4 → all outputs at reset values immediately. Release with the same pattern held → commit at edge 5 after release. Separately, run 256 legal commits → change_count wraps to 0.
